// File: rtl/fc_argmax.sv
// fc_argmax: scans the FC layer's packed class scores one per clock and reports the argmax.
// Define ARGMAX_SCORE_OUT_EN to also export the winning score on max_score.
module fc_argmax #(
  parameter int  BITWIDTH    = 8,
  parameter int  FILTERBATCH = 10,
  localparam int IDXW        = (FILTERBATCH > 1) ? $clog2(FILTERBATCH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clken,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BITWIDTH*2*FILTERBATCH-1:0] scores,
  output logic                            out_valid,
  output logic [IDXW-1:0]                 class_idx,
  output logic                            busy
`ifdef ARGMAX_SCORE_OUT_EN
  ,
  output logic signed [BITWIDTH*2-1:0]    max_score
`endif
);

  localparam int SW = 2 * BITWIDTH;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FILTERBATCH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state;
  logic signed [SW-1:0] shadow_p0 [FILTERBATCH];
  logic [IDXW-1:0]      cnt_p0;
  logic signed [SW-1:0] best_val_p1;
  logic [IDXW-1:0]      best_idx_p1;
  logic signed [SW-1:0] cand_val;
  logic signed [SW-1:0] nxt_val;
  logic [IDXW-1:0]      nxt_idx;
  logic                 accept;

  function automatic logic signed [SW-1:0] entry(input logic [SW*FILTERBATCH-1:0] vec,
                                                 input int k);
    return $signed(vec[k*SW +: SW]);
  endfunction

  assign in_ready = (state == IDLE) && clken;
  assign accept   = in_valid && in_ready;
  assign cand_val = shadow_p0[cnt_p0];

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nxt_val = best_val_p1;
    nxt_idx = best_idx_p1;
    if (cand_val > best_val_p1) begin
      nxt_val = cand_val;
      nxt_idx = cnt_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      class_idx   <= '0;
      busy        <= 1'b0;
      cnt_p0      <= '0;
      best_val_p1 <= '0;
      best_idx_p1 <= '0;
      for (int k = 0; k < FILTERBATCH; k++) shadow_p0[k] <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
      max_score   <= '0;
`endif
    end else begin
      case (state)
        // Capture stage: the shadow copy frees the upstream register immediately.
        IDLE: begin
          out_valid <= 1'b0;
          if (accept) begin
            for (int k = 0; k < FILTERBATCH; k++) shadow_p0[k] <= entry(scores, k);
            best_val_p1 <= entry(scores, 0);
            best_idx_p1 <= '0;
            cnt_p0      <= IDXW'(1);
            busy        <= 1'b1;
            if (FILTERBATCH == 1) begin
              class_idx <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
`ifdef ARGMAX_SCORE_OUT_EN
              max_score <= entry(scores, 0);
`endif
            end else begin
              state <= SCAN;
            end
          end
        end
        // Compare stage: one entry per enabled clock.
        SCAN: begin
          if (clken) begin
            best_val_p1 <= nxt_val;
            best_idx_p1 <= nxt_idx;
            if (cnt_p0 == LAST_IDX) begin
              class_idx <= nxt_idx;
              out_valid <= 1'b1;
              state     <= DONE;
`ifdef ARGMAX_SCORE_OUT_EN
              max_score <= nxt_val;
`endif
            end else begin
              cnt_p0 <= cnt_p0 + IDXW'(1);
            end
          end
        end
        // Result stage: the pulse always retires, even with clken low.
        DONE: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
